zr_test_ctrl: RTL and testbench

ZR_TEST_CTRL -- requirements
Module: zr_test_ctrl

---
 rtl/zr_test_pkg.sv | 25 ++
 rtl/zr_irq_seq.sv | 104 ++++++++++
 rtl/zr_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_zr_test_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zr_test_pkg.sv
// zr_test_pkg: shared types and constants for the test controller.
//   main_state_e : overall test verdict FSM (run / pass / fail / timeout)
//   irq_state_e  : interrupt sequencer FSM (wait / request / gap / finished)
//   TOHOST_PC    : PC of the tohost store that signals end of test
//   RESULT_PASS  : value of x3 that marks a passing test
package zr_test_pkg;

    typedef enum logic [1:0] {
        MainRun,
        MainPass,
        MainFail,
        MainTout
    } main_state_e;

    typedef enum logic [1:0] {
        IrqWait,
        IrqReq,
        IrqGap,
        IrqFin
    } irq_state_e;

    localparam logic [31:0] TOHOST_PC   = 32'h0000_010e;
    localparam logic [31:0] RESULT_PASS = 32'd1;

endpackage

// File: rtl/zr_irq_seq.sv
// zr_irq_seq: raises N_IRQ interrupt requests with IDs 0..N_IRQ-1 in order.
// The first request rises at cycle IRQ_START; each correct ack drops the
// request, and the next one rises after IRQ_GAP idle cycles.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   cycle_cnt_i   : free-running cycle count from the top
//   done_i        : test finished; retires the sequencer
//   irq_ack_i     : interrupt acknowledge from the core
//   irq_ack_id_i  : ID being acknowledged
//   irq_o         : interrupt request (registered)
//   irq_id_o      : ID of the request (registered)
//   irq_err_o     : sticky, an ack carried the wrong ID
module zr_irq_seq
    import zr_test_pkg::*;
#(
    parameter int unsigned N_IRQ     = 4,
    parameter int unsigned IRQ_START = 2048,
    parameter int unsigned IRQ_GAP   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cycle_cnt_i,
    input  logic        done_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic        irq_o,
    output logic [4:0]  irq_id_o,
    output logic        irq_err_o
);

    localparam int unsigned GapW = (IRQ_GAP > 1) ? $clog2(IRQ_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(IRQ_GAP - 1);
    localparam logic [4:0]      ChLast  = 5'(N_IRQ - 1);
    // Leave WAIT one cycle early so the registered irq_o rises at IRQ_START.
    localparam logic [31:0]     StartM1 = 32'(IRQ_START - 1);

    irq_state_e      state_q;
    logic [4:0]      ch_q;
    logic [GapW-1:0] gap_q;
    logic            irq_q;
    logic [4:0]      id_q;
    logic            err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IrqWait;
            ch_q    <= 5'd0;
            gap_q   <= '0;
            irq_q   <= 1'b0;
            id_q    <= 5'd0;
            err_q   <= 1'b0;
        end else if (done_i) begin
            // Test over: abandon any outstanding request.
            state_q <= IrqFin;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IrqWait: begin
                    if (cycle_cnt_i == StartM1) begin
                        state_q <= IrqReq;
                        irq_q   <= 1'b1;
                        id_q    <= ch_q;
                    end
                end
                IrqReq: begin
                    if (irq_ack_i) begin
                        if (irq_ack_id_i == ch_q) begin
                            irq_q <= 1'b0;
                            if (ch_q == ChLast) begin
                                state_q <= IrqFin;
                            end else begin
                                state_q <= IrqGap;
                                ch_q    <= ch_q + 5'd1;
                                gap_q   <= GapLast;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                IrqGap: begin
                    if (gap_q == '0) begin
                        state_q <= IrqReq;
                        irq_q   <= 1'b1;
                        id_q    <= ch_q;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                IrqFin: begin
                end
                default: begin
                    state_q <= IrqFin;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = id_q;
    assign irq_err_o = err_q;

endmodule

// File: rtl/zr_test_ctrl.sv
// zr_test_ctrl: testbench-side controller for a core running a self-test.
// Counts cycles, detects the tohost store PC, decides pass/fail/timeout and
// drives a short interrupt sequence into the core.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pc_i/pc_vld_i : PC of the instruction in ID and its valid
//   x3_i          : core register x3 (test result)
//   irq_ack_i     : interrupt acknowledge, irq_ack_id_i its ID
//   irq_o/irq_id_o: interrupt request and its ID
//   cycle_cnt_o   : free-running cycle count, frozen once done
//   hit_cnt_o     : END_PC hit count (saturating)
//   end_cycle_o   : cycle of the first END_PC hit
//   done_o, pass_o, timeout_o, irq_err_o : sticky status flags
module zr_test_ctrl
    import zr_test_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned PC_CMP_W  = 28,
    parameter logic [31:0] END_PC    = TOHOST_PC,
    parameter int unsigned END_HITS  = 8,
    parameter int unsigned WDOG_BIT  = 20,
    parameter int unsigned N_IRQ     = 4,
    parameter int unsigned IRQ_START = 2048,
    parameter int unsigned IRQ_GAP   = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_i,
    input  logic            pc_vld_i,
    input  logic [31:0]     x3_i,
    input  logic            irq_ack_i,
    input  logic [4:0]      irq_ack_id_i,
    output logic            irq_o,
    output logic [4:0]      irq_id_o,
    output logic [31:0]     cycle_cnt_o,
    output logic [7:0]      hit_cnt_o,
    output logic [31:0]     end_cycle_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            timeout_o,
    output logic            irq_err_o
);

    localparam logic [7:0] TermCnt = 8'(END_HITS - 1);

    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic [31:0] end_cycle_q, end_cycle_d;
    main_state_e state_q;
    logic        done_q, pass_q, tout_q;

    logic hit, term_hit, wdog;

    // Upper PC bits are don't-care so RAM and flash boot addresses both match.
    assign hit      = pc_vld_i && (pc_i[PC_CMP_W-1:0] == END_PC[PC_CMP_W-1:0]) && !done_q;
    assign term_hit = hit && (hit_cnt_q == TermCnt);
    assign wdog     = cycle_cnt_q[WDOG_BIT];

    if (PC_W > PC_CMP_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^pc_i[PC_W-1:PC_CMP_W];
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        end_cycle_d = end_cycle_q;
        if (!done_q) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (hit) begin
            if (hit_cnt_q != 8'hff) begin
                hit_cnt_d = hit_cnt_q + 8'd1;
            end
            if (hit_cnt_q == 8'd0) begin
                end_cycle_d = cycle_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 32'd0;
            hit_cnt_q   <= 8'd0;
            end_cycle_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            end_cycle_q <= end_cycle_d;
        end
    end

    // Verdict FSM; the terminal hit wins over a coincident watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MainRun;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            case (state_q)
                MainRun: begin
                    if (term_hit) begin
                        done_q <= 1'b1;
                        if (x3_i == RESULT_PASS) begin
                            state_q <= MainPass;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= MainFail;
                        end
                    end else if (wdog) begin
                        state_q <= MainTout;
                        done_q  <= 1'b1;
                        tout_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    zr_irq_seq #(
        .N_IRQ     (N_IRQ),
        .IRQ_START (IRQ_START),
        .IRQ_GAP   (IRQ_GAP)
    ) u_irq_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .cycle_cnt_i  (cycle_cnt_q),
        .done_i       (done_q),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_err_o    (irq_err_o)
    );

    assign cycle_cnt_o = cycle_cnt_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign end_cycle_o = end_cycle_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = tout_q;

endmodule

// File: tb/tb_zr_test_ctrl.sv
// Bench for zr_test_ctrl. Main instance: WDOG_BIT=12, N_IRQ=2, IRQ_GAP=4.
// Second instance with WDOG_BIT=10 and idle inputs exercises the watchdog.
module tb_zr_test_ctrl;

    localparam int unsigned WDOG_BIT  = 12;
    localparam int unsigned N_IRQ     = 2;
    localparam int unsigned IRQ_GAP   = 4;
    localparam int unsigned IRQ_START = 2048;
    localparam int unsigned END_HITS  = 8;
    localparam logic [31:0] END_PC    = 32'h0000_010e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_w;
    logic        pc_vld;
    logic [31:0] pc, x3;
    logic        ack;
    logic [4:0]  ack_id;

    logic        irq, done, pass, tout, err;
    logic [4:0]  irq_id;
    logic [31:0] cyc, endc;
    logic [7:0]  hits;

    logic        w_irq, w_done, w_pass, w_tout, w_err;
    logic [4:0]  w_irq_id;
    logic [31:0] w_cyc, w_endc;
    logic [7:0]  w_hits;

    zr_test_ctrl #(
        .PC_W(32), .PC_CMP_W(28), .END_PC(END_PC), .END_HITS(END_HITS),
        .WDOG_BIT(WDOG_BIT), .N_IRQ(N_IRQ), .IRQ_START(IRQ_START), .IRQ_GAP(IRQ_GAP)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_vld_i(pc_vld), .x3_i(x3),
        .irq_ack_i(ack), .irq_ack_id_i(ack_id), .irq_o(irq), .irq_id_o(irq_id),
        .cycle_cnt_o(cyc), .hit_cnt_o(hits), .end_cycle_o(endc), .done_o(done),
        .pass_o(pass), .timeout_o(tout), .irq_err_o(err)
    );

    zr_test_ctrl #(
        .WDOG_BIT(10)
    ) u_dut_wdog (
        .clk(clk), .rst_n(rst_n_w), .pc_i(32'd0), .pc_vld_i(1'b0), .x3_i(32'd0),
        .irq_ack_i(1'b0), .irq_ack_id_i(5'd0), .irq_o(w_irq), .irq_id_o(w_irq_id),
        .cycle_cnt_o(w_cyc), .hit_cnt_o(w_hits), .end_cycle_o(w_endc), .done_o(w_done),
        .pass_o(w_pass), .timeout_o(w_tout), .irq_err_o(w_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] x3;
        logic [7:0]  hits;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_vld = 1'b0;
        pc     = 32'd0;
        x3     = 32'd0;
        ack    = 1'b0;
        ack_id = 5'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " irq"}, irq, 1'b0);
        chk({tag, " irq_id"}, 32'(irq_id), 32'd0);
        chk({tag, " cycle"}, cyc, 32'd0);
        chk({tag, " hits"}, 32'(hits), 32'd0);
        chk({tag, " end_cycle"}, endc, 32'd0);
        chk1({tag, " done"}, done, 1'b0);
        chk1({tag, " pass"}, pass, 1'b0);
        chk1({tag, " timeout"}, tout, 1'b0);
        chk1({tag, " irq_err"}, err, 1'b0);
    endtask

    task automatic do_reset();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first cycle", cyc, 32'd1);
    endtask

    task automatic run_to(input logic [31:0] n);
        for (int i = 0; i < 5000; i++) begin
            if (cyc == n) break;
            tick();
        end
        chk("run_to", cyc, n);
    endtask

    // One random round checked against a cycle-level model of the test rules.
    task automatic rand_round();
        int unsigned m_cyc, m_hits, m_end;
        bit          m_done, m_pass, m_tout, m_hit;
        do_reset();
        m_cyc = 1; m_hits = 0; m_end = 0;
        m_done = 0; m_pass = 0; m_tout = 0;
        for (int i = 0; i < 400; i++) begin
            pc_vld = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 3))
                0:       pc = $urandom();
                1:       pc = END_PC ^ (32'd1 << $urandom_range(0, 27));
                default: pc = ($urandom() & 32'hF000_0000) | END_PC;
            endcase
            x3     = ($urandom_range(0, 1) != 0) ? 32'd1 : $urandom();
            ack    = 1'($urandom_range(0, 1));
            ack_id = 5'($urandom());
            m_hit  = pc_vld && (((pc ^ END_PC) & 32'h0FFF_FFFF) == 0) && !m_done;
            if (!m_done) begin
                if (m_hit) begin
                    if (m_hits == 0) m_end = m_cyc;
                    if (m_hits < 255) m_hits++;
                end
                if (m_hit && m_hits == END_HITS) begin
                    m_done = 1;
                    m_pass = (x3 == 32'd1);
                end else if (((m_cyc >> WDOG_BIT) & 1) != 0) begin
                    m_done = 1;
                    m_tout = 1;
                end
                m_cyc++;
            end
            tick();
            chk("rnd cycle", cyc, m_cyc);
            chk("rnd hits", 32'(hits), m_hits);
            chk("rnd end_cycle", endc, m_end);
            chk1("rnd done", done, m_done);
            chk1("rnd pass", pass, m_pass);
            chk1("rnd timeout", tout, m_tout);
            chk1("rnd irq", irq, 1'b0);
            chk1("rnd irq_err", err, 1'b0);
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        // vld, pc, x3, expected hits/done/pass after the edge
        tbl[0]  = '{1'b1, 32'h0000_010e, 32'd0, 8'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_010e, 32'd0, 8'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h2000_010e, 32'd0, 8'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_010c, 32'd0, 8'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h1000_010e, 32'd0, 8'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h0100_010e, 32'd1, 8'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_010e, 32'd7, 8'd4, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_010e, 32'd7, 8'd5, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_010e, 32'd7, 8'd6, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h8000_010e, 32'd7, 8'd7, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_010e, 32'd1, 8'd8, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_010e, 32'd0, 8'd8, 1'b1, 1'b1};

        // Both instances come out of reset together.
        idle_inputs();
        rst_n   = 1'b0;
        rst_n_w = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("por");
        chk("por wdog cycle", w_cyc, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rst_n_w = 1'b1;
        tick();
        chk("por first cycle", cyc, 32'd1);
        chk("por wdog first cycle", w_cyc, 32'd1);

        // Watchdog instance, then IRQ sequence with acks 3 cycles after rise.
        run_to(32'd1024);
        chk1("wdog early", w_tout, 1'b0);
        chk("wdog cycle 1024", w_cyc, 32'd1024);
        tick();
        chk1("wdog timeout", w_tout, 1'b1);
        chk1("wdog done", w_done, 1'b1);
        chk1("wdog pass", w_pass, 1'b0);
        chk("wdog frozen", w_cyc, 32'd1025);
        run_to(32'd2047);
        chk1("irq before start", irq, 1'b0);
        chk("wdog still frozen", w_cyc, 32'd1025);
        tick();
        chk1("irq0 rise", irq, 1'b1);
        chk("irq0 id", 32'(irq_id), 32'd0);
        chk1("wdog no irq", w_irq, 1'b0);
        tick();
        chk1("irq0 2049", irq, 1'b1);
        tick();
        chk1("irq0 2050", irq, 1'b1);
        ack = 1'b1; ack_id = 5'd0;
        tick();
        chk1("irq0 dropped", irq, 1'b0);
        ack_id = 5'd1;
        tick();
        ack = 1'b0;
        chk1("gap 2052", irq, 1'b0);
        chk1("gap ack ignored", err, 1'b0);
        tick();
        chk1("gap 2053", irq, 1'b0);
        tick();
        chk1("gap 2054", irq, 1'b0);
        tick();
        chk("cycle irq1", cyc, 32'd2055);
        chk1("irq1 rise", irq, 1'b1);
        chk("irq1 id", 32'(irq_id), 32'd1);
        tick();
        tick();
        chk1("irq1 2057", irq, 1'b1);
        ack = 1'b1; ack_id = 5'd1;
        tick();
        chk1("irq1 dropped", irq, 1'b0);
        ack_id = 5'd0;
        run_to(32'd2200);
        ack = 1'b0;
        chk1("fin irq", irq, 1'b0);
        chk1("fin err", err, 1'b0);
        chk1("fin done", done, 1'b0);

        // Wrong-ID ack, then reset pulsed in the middle of a request.
        do_reset();
        run_to(32'd2048);
        chk1("b irq0", irq, 1'b1);
        ack = 1'b1; ack_id = 5'd3;
        tick();
        chk1("b bad ack keeps irq", irq, 1'b1);
        chk1("b irq_err", err, 1'b1);
        ack_id = 5'd0;
        tick();
        ack = 1'b0;
        chk1("b good ack drops irq", irq, 1'b0);
        chk1("b irq_err sticky", err, 1'b1);
        run_to(32'd2054);
        chk1("b irq1", irq, 1'b1);
        chk("b irq1 id", 32'(irq_id), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-request reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("b restart cycle", cyc, 32'd1);
        run_to(32'd2047);
        chk1("b restart quiet", irq, 1'b0);
        tick();
        chk1("b restart irq", irq, 1'b1);
        chk("b restart id", 32'(irq_id), 32'd0);
        chk1("b restart err", err, 1'b0);

        // Table-driven hit sequence, first hit at cycle 500.
        do_reset();
        run_to(32'd500);
        for (int i = 0; i < 12; i++) begin
            pc_vld = tbl[i].vld;
            pc     = tbl[i].pc;
            x3     = tbl[i].x3;
            tick();
            chk($sformatf("tbl[%0d] hits", i), 32'(hits), 32'(tbl[i].hits));
            chk1($sformatf("tbl[%0d] done", i), done, tbl[i].done);
            chk1($sformatf("tbl[%0d] pass", i), pass, tbl[i].pass);
        end
        idle_inputs();
        chk("tbl end_cycle", endc, 32'd500);
        chk("tbl cycle", cyc, 32'd511);
        chk1("tbl timeout", tout, 1'b0);
        repeat (20) tick();
        chk("tbl cycle frozen", cyc, 32'd511);
        chk("tbl hits held", 32'(hits), 32'd8);

        // Eight hits, x3 wrong on the last one: fail.
        do_reset();
        run_to(32'd100);
        for (int i = 0; i < 8; i++) begin
            pc_vld = 1'b1;
            pc     = END_PC;
            x3     = (i == 7) ? 32'd5 : 32'd1;
            tick();
        end
        idle_inputs();
        chk1("fail done", done, 1'b1);
        chk1("fail pass", pass, 1'b0);
        chk1("fail timeout", tout, 1'b0);
        chk("fail hits", 32'(hits), 32'd8);
        chk("fail end_cycle", endc, 32'd100);

        // Eighth hit lands on the first watchdog cycle; IRQ 0 still pending.
        do_reset();
        run_to(32'd4089);
        chk1("coin irq pending", irq, 1'b1);
        for (int i = 0; i < 8; i++) begin
            pc_vld = 1'b1;
            pc     = END_PC;
            x3     = (i == 7) ? 32'd1 : 32'd0;
            tick();
        end
        idle_inputs();
        chk1("coin done", done, 1'b1);
        chk1("coin pass", pass, 1'b1);
        chk1("coin timeout", tout, 1'b0);
        chk("coin end_cycle", endc, 32'd4089);
        chk1("coin irq still up", irq, 1'b1);
        tick();
        chk1("coin irq dropped", irq, 1'b0);
        chk("coin cycle frozen", cyc, 32'd4097);

        for (int r = 0; r < 3; r++) rand_round();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
